// File: rtl/spd_reconfig_ctrl.sv
// Link-speed reconfiguration sequencer: requests a transceiver rate change,
// holds the receiver in reset, waits for CDR lock and a settle window, then commits.
module spd_reconfig_ctrl #(
  parameter int SIM_ONLY  = 0,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cfg_LE_LINKSPEED,
  input  logic       rx_is_lockedtodata,
  input  logic       reconfig_done,
  output logic       reconfig_req,
  output logic [3:0] reconfig_rate,
  output logic       rx_analogreset,
  output logic [3:0] stat_LE_LINKSPEED,
  output logic       mon_mask,
  output logic       spd_fail,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_RST_HOLD  = 3'd3,
    S_WAIT_LOCK = 3'd4,
    S_SETTLE    = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  // Terminal counts are one less than the timer length: counters start at 0.
  localparam logic [10:0] HOLD_LAST   = (SIM_ONLY != 0) ? 11'd15 : 11'd1023;
  localparam logic [20:0] LOCK_LAST   = (SIM_ONLY != 0) ? 21'd63 : 21'd1048575;
  localparam logic [20:0] LOCK_SAT    = LOCK_LAST + 21'd1;
  localparam logic [8:0]  SETTLE_LAST = (SIM_ONLY != 0) ? 9'd7 : 9'd255;
  localparam logic [3:0]  MAX_R       = 4'(MAX_RETRY);

  state_t      state;
  logic        sync_meta;
  logic        lock;
  logic [3:0]  target;
  logic [2:0]  retry_cnt;
  logic [10:0] hold_cnt;
  logic [8:0]  set_cnt;
  logic [20:0] to_cnt;
  logic        cfg_valid;
  logic [3:0]  retry_inc;
  logic        retry_left;

  assign cfg_valid  = cfg_LE_LINKSPEED inside {4'h1, 4'h2, 4'h4, 4'h8};
  assign retry_inc  = {1'b0, retry_cnt} + 4'd1;
  assign retry_left = retry_inc < MAX_R;
  assign fsm_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      lock      <= 1'b0;
    end else begin
      sync_meta <= rx_is_lockedtodata;
      lock      <= sync_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      reconfig_req      <= 1'b0;
      reconfig_rate     <= 4'h1;
      rx_analogreset    <= 1'b1;
      stat_LE_LINKSPEED <= 4'h1;
      mon_mask          <= 1'b1;
      spd_fail          <= 1'b0;
      busy              <= 1'b0;
      target            <= 4'h1;
      retry_cnt         <= 3'd0;
      hold_cnt          <= 11'd0;
      set_cnt           <= 9'd0;
      to_cnt            <= 21'd0;
    end else begin
      mon_mask <= (state != S_IDLE) || !lock;
      case (state)
        S_IDLE: begin
          rx_analogreset <= 1'b0;
          if (cfg_valid && (cfg_LE_LINKSPEED != stat_LE_LINKSPEED)) begin
            target        <= cfg_LE_LINKSPEED;
            reconfig_rate <= cfg_LE_LINKSPEED;
            retry_cnt     <= 3'd0;
            reconfig_req  <= 1'b1;
            busy          <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (reconfig_done) begin
            reconfig_req   <= 1'b0;
            rx_analogreset <= 1'b1;
            hold_cnt       <= 11'd0;
            state          <= S_RST_HOLD;
          end
        end
        S_RST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            rx_analogreset <= 1'b0;
            to_cnt         <= 21'd0;
            state          <= S_WAIT_LOCK;
          end else begin
            hold_cnt <= hold_cnt + 11'd1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock) begin
            set_cnt <= 9'd0;
            state   <= S_SETTLE;
            if (to_cnt != LOCK_SAT) to_cnt <= to_cnt + 21'd1;
          end else if (to_cnt >= LOCK_LAST) begin
            retry_cnt <= retry_inc[2:0];
            if (retry_left) begin
              reconfig_req  <= 1'b1;
              reconfig_rate <= target;
              state         <= S_REQ;
            end else begin
              spd_fail <= 1'b1;
              busy     <= 1'b0;
              state    <= S_FAIL;
            end
          end else begin
            to_cnt <= to_cnt + 21'd1;
          end
        end
        S_SETTLE: begin
          // The lock timeout keeps running across settle attempts.
          if (to_cnt != LOCK_SAT) to_cnt <= to_cnt + 21'd1;
          if (!lock) begin
            state <= S_WAIT_LOCK;
          end else if (set_cnt == SETTLE_LAST) begin
            stat_LE_LINKSPEED <= target;
            busy              <= 1'b0;
            state             <= S_IDLE;
          end else begin
            set_cnt <= set_cnt + 9'd1;
          end
        end
        S_FAIL: begin
          if (cfg_valid && (cfg_LE_LINKSPEED != target) &&
              (cfg_LE_LINKSPEED != stat_LE_LINKSPEED)) begin
            target        <= cfg_LE_LINKSPEED;
            reconfig_rate <= cfg_LE_LINKSPEED;
            retry_cnt     <= 3'd0;
            spd_fail      <= 1'b0;
            reconfig_req  <= 1'b1;
            busy          <= 1'b1;
            state         <= S_REQ;
          end else if (cfg_LE_LINKSPEED == stat_LE_LINKSPEED) begin
            spd_fail <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
